// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - line memory with automatic init sweep after reset or on request
//   clk_i       single rising-edge clock
//   rst_i       synchronous active-high reset, restarts the sweep
//   init_req_i  request a full re-initialisation sweep (honoured only when ready)
//   rd_en_i     read strobe, data_o/valid_o one cycle later
//   wr_en_i     write strobe, byte-enabled by wr_be_i
//   addr_i      shared read/write line address
//   wr_data_i   write data
//   wr_be_i     byte enables, bit k covers bits [8k+7:8k]
//   data_o      registered read data, holds when no read is accepted
//   valid_o     data_o carries a fresh read result
//   busy_o      init sweep in progress
//   done_o      one-cycle pulse when a sweep completes
module ram_init_seq #(
   parameter int LINE_WIDTH = 128,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int INIT_MODE  = 0,
   parameter logic [LINE_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    init_req_i,
   input  logic                    rd_en_i,
   input  logic                    wr_en_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [LINE_WIDTH-1:0]   wr_data_i,
   input  logic [LINE_WIDTH/8-1:0] wr_be_i,
   output logic [LINE_WIDTH-1:0]   data_o,
   output logic                    valid_o,
   output logic                    busy_o,
   output logic                    done_o
);

   typedef enum logic {INIT, READY} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   // One extra bit so DEPTH itself is representable for the range check.
   localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
   logic                    done_next;
   logic [LINE_WIDTH-1:0]   mem [DEPTH];
   logic [LINE_WIDTH-1:0]   fill_line;
   logic                    in_range;
   logic                    rd_accept;
   logic                    wr_accept;

   assign in_range  = ({1'b0, addr_i} < DEPTH_CMP);
   // An init request in READY swallows any read or write presented alongside it.
   assign rd_accept = (state == READY) && rd_en_i && !init_req_i;
   assign wr_accept = (state == READY) && wr_en_i && !init_req_i && in_range;
   assign busy_o    = (state == INIT);

   generate
      if (INIT_MODE == 1) begin : g_tagged
         assign fill_line = INIT_VALUE ^ {{(LINE_WIDTH - ADDR_WIDTH){1'b0}}, cnt};
      end else begin : g_const
         assign fill_line = INIT_VALUE;
      end
   endgenerate

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_next  = 1'b0;
      case (state)
         INIT: begin
            if (cnt == LAST_ADDR) begin
               state_next = READY;
               cnt_next   = '0;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt + ADDR_WIDTH'(1);
            end
         end
         READY: begin
            if (init_req_i) begin
               state_next = INIT;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = INIT;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= INIT;
         cnt     <= '0;
         done_o  <= 1'b0;
         valid_o <= 1'b0;
         data_o  <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         done_o  <= done_next;
         valid_o <= rd_accept;
         if (rd_accept) begin
            data_o <= in_range ? mem[addr_i] : '0;
         end
      end
   end

   // Memory has no reset; its contents become defined by the sweep that follows.
   // Non-blocking update gives read-first behaviour on a same-address read/write.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state == INIT) begin
            mem[cnt] <= fill_line;
         end else if (wr_accept) begin
            for (int k = 0; k < LINE_WIDTH / 8; k++) begin
               if (wr_be_i[k]) begin
                  mem[addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
               end
            end
         end
      end
   end

endmodule

// File: doc/ram_init_seq.md
RAM_INIT_SEQ -- requirements
Module: ram_init_seq

Interface
REQ-001 The module SHALL have parameter LINE_WIDTH, default 128, meaning bits per memory line; must be a multiple of 8.
REQ-002 The module SHALL have parameter DEPTH, default 32, meaning the number of lines.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), meaning the address width.
REQ-004 The module SHALL have parameter INIT_MODE, default 0, meaning 0 = constant fill, 1 = address-tagged fill.
REQ-005 The module SHALL have parameter INIT_VALUE, default 0 (LINE_WIDTH bits), meaning the fill constant or XOR seed.
REQ-006 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port init_req_i, input, 1 bit: request a full re-initialisation sweep.
REQ-009 The module SHALL have port rd_en_i, input, 1 bit: read strobe.
REQ-010 The module SHALL have port wr_en_i, input, 1 bit: write strobe.
REQ-011 The module SHALL have port addr_i, input, ADDR_WIDTH bits: shared read/write line address.
REQ-012 The module SHALL have port wr_data_i, input, LINE_WIDTH bits: write data.
REQ-013 The module SHALL have port wr_be_i, input, LINE_WIDTH/8 bits: byte enables; bit k covers bits [8k+7:8k].
REQ-014 The module SHALL have port data_o, output, LINE_WIDTH bits: registered read data.
REQ-015 The module SHALL have port valid_o, output, 1 bit: data_o holds a valid read result this cycle.
REQ-016 The module SHALL have port busy_o, output, 1 bit: the init sweep is in progress.
REQ-017 The module SHALL have port done_o, output, 1 bit: one-cycle pulse when a sweep completes.

Function
REQ-018 The FSM SHALL have two states, INIT and READY, plus a sweep counter cnt (ADDR_WIDTH bits).
REQ-019 In INIT, each cycle SHALL write line[cnt] = fill(cnt) and increment cnt.
REQ-020 fill(a) SHALL be INIT_VALUE when INIT_MODE=0, and INIT_VALUE XOR zero-extended a when INIT_MODE=1.
REQ-021 When INIT writes cnt==DEPTH-1, the FSM SHALL enter READY on the next edge, clear cnt to 0, and assert done_o for exactly that one following cycle.
REQ-022 The sweep SHALL take exactly DEPTH cycles; busy_o=1 iff the state is INIT.
REQ-023 The sweep SHALL terminate at DEPTH-1 even when DEPTH is not a power of two; addresses >= DEPTH are never written.
REQ-024 In INIT, rd_en_i, wr_en_i and init_req_i SHALL be ignored: no write, valid_o=0, and the sweep is not restarted.
REQ-025 In READY, wr_en_i=1 SHALL update only the bytes of line[addr_i] whose wr_be_i bit is 1; wr_be_i=0 leaves the line unchanged.
REQ-026 In READY, rd_en_i=1 SHALL drive data_o=line[addr_i] and valid_o=1 on the next cycle (1-cycle latency).
REQ-027 When no read was accepted, valid_o SHALL be 0 and data_o SHALL hold its last value.
REQ-028 On a same-cycle read and write to the same address, the read SHALL return the pre-write contents (read-first).
REQ-029 In READY, init_req_i=1 SHALL move the FSM to INIT with cnt=0 on the next edge, and any write or read that same cycle SHALL be dropped (valid_o=0 next cycle).
REQ-030 An out-of-range addr_i (>= DEPTH) in READY SHALL make a write have no effect and a read return valid_o=1 with data_o=0.

Reset
REQ-031 When rst_i=1 at an edge, the module SHALL set state=INIT, cnt=0, data_o=0, valid_o=0, done_o=0, with busy_o=1 following from the state.
REQ-032 Reset SHALL take priority over all other inputs, including mid-sweep, where it restarts the sweep from line 0.
REQ-033 Memory contents SHALL NOT be cleared directly by reset; they are defined only after the sweep that follows reset.
REQ-034 After rst_i is released, the first sweep SHALL begin on the first edge with rst_i=0.

Verification
REQ-035 Reset release, defaults: busy_o=1 for 32 cycles, then done_o pulses once; reading lines 0..31 returns 0 with valid_o=1 one cycle after each rd_en_i.
REQ-036 INIT_MODE=1, INIT_VALUE=128'hA5..A5: after the sweep, read of addr 5 returns 128'hA5..A0 (A5..A5 XOR 5).
REQ-037 Byte-enable write: write addr 3 with data 128'hFF..FF, wr_be_i=16'h0003; the read returns 128'h0..0FFFF.
REQ-038 Same-cycle read+write to addr 7 (old 0, new all-ones, full BE): data_o=0 next cycle; the following read returns all-ones.
REQ-039 init_req_i asserted together with wr_en_i at addr 2: the write is dropped, busy_o=1 for 32 cycles, and line 2 equals fill(2) afterwards.
REQ-040 rst_i pulsed at sweep cycle 10: the sweep restarts from cnt=0, and done_o occurs 32 cycles after rst_i is released; DEPTH=20 build: the sweep takes 20 cycles.
